// File: rtl/register_bank_dump_if.sv
// Write-back, dump stream and per-register read bus for register_bank_dump.
// The design attaches to the slave modport; the write-back source and the dump sink use master.
interface register_bank_dump_if #(
    parameter int unsigned N = 32
);
    logic         reg_write_i;
    logic [4:0]   write_register_i;
    logic [N-1:0] write_data_i;

    logic         dump_start_i;
    logic         dump_ready_i;
    logic         dump_valid_o;
    logic [4:0]   dump_index_o;
    logic [N-1:0] dump_data_o;
    logic         dump_busy_o;
    logic         dump_done_o;

    logic [N-1:0] data_0_o,  data_1_o,  data_2_o,  data_3_o,  data_4_o,  data_5_o,  data_6_o,  data_7_o;
    logic [N-1:0] data_8_o,  data_9_o,  data_10_o, data_11_o, data_12_o, data_13_o, data_14_o, data_15_o;
    logic [N-1:0] data_16_o, data_17_o, data_18_o, data_19_o, data_20_o, data_21_o, data_22_o, data_23_o;
    logic [N-1:0] data_24_o, data_25_o, data_26_o, data_27_o, data_28_o, data_29_o, data_30_o, data_31_o;

    modport master (
        output reg_write_i, write_register_i, write_data_i, dump_start_i, dump_ready_i,
        input  dump_valid_o, dump_index_o, dump_data_o, dump_busy_o, dump_done_o,
        input  data_0_o,  data_1_o,  data_2_o,  data_3_o,  data_4_o,  data_5_o,  data_6_o,  data_7_o,
        input  data_8_o,  data_9_o,  data_10_o, data_11_o, data_12_o, data_13_o, data_14_o, data_15_o,
        input  data_16_o, data_17_o, data_18_o, data_19_o, data_20_o, data_21_o, data_22_o, data_23_o,
        input  data_24_o, data_25_o, data_26_o, data_27_o, data_28_o, data_29_o, data_30_o, data_31_o
    );

    modport slave (
        input  reg_write_i, write_register_i, write_data_i, dump_start_i, dump_ready_i,
        output dump_valid_o, dump_index_o, dump_data_o, dump_busy_o, dump_done_o,
        output data_0_o,  data_1_o,  data_2_o,  data_3_o,  data_4_o,  data_5_o,  data_6_o,  data_7_o,
        output data_8_o,  data_9_o,  data_10_o, data_11_o, data_12_o, data_13_o, data_14_o, data_15_o,
        output data_16_o, data_17_o, data_18_o, data_19_o, data_20_o, data_21_o, data_22_o, data_23_o,
        output data_24_o, data_25_o, data_26_o, data_27_o, data_28_o, data_29_o, data_30_o, data_31_o
    );
endinterface

// File: rtl/register_bank_dump.sv
// MIPS 32-entry register storage with hard-wired $zero, $gp/$sp reset values,
// and a valid/ready engine that streams all registers out in index order.
module register_bank_dump #(
    parameter int unsigned N        = 32,
    parameter logic [31:0] GP_RESET = 32'h1000_8000,
    parameter logic [31:0] SP_RESET = 32'h7FFF_EFFC
) (
    input logic                  clk,
    input logic                  reset,
    register_bank_dump_if.slave  bus
);
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned IDX_W    = 5;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    logic [N-1:0]     regs [NUM_REGS];
    state_t           state_q, state_d;
    logic [IDX_W-1:0] index_q, index_d, next_idx;
    logic [N-1:0]     snap_q, snap_d;
    logic             valid_q, busy_q, done_q;

    function automatic logic [N-1:0] reset_value(input int unsigned k);
        if (k == 28) return N'(GP_RESET);
        if (k == 29) return N'(SP_RESET);
        return '0;
    endfunction

    // Write-back port; index 0 is never written so it stays zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= reset_value(i);
        end else if (bus.reg_write_i && bus.write_register_i != '0) begin
            regs[bus.write_register_i] <= bus.write_data_i;
        end
    end

    // Dump sequencing; the next snapshot honours a same-edge write (write-first)
    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        snap_d   = snap_q;
        next_idx = index_q + IDX_W'(1);
        unique case (state_q)
            IDLE: begin
                if (bus.dump_start_i) begin
                    state_d = SEND;
                    index_d = '0;
                    snap_d  = '0;
                end
            end
            SEND: begin
                if (bus.dump_ready_i) begin
                    if (index_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        index_d = next_idx;
                        snap_d  = (bus.reg_write_i && bus.write_register_i == next_idx)
                                  ? bus.write_data_i : regs[next_idx];
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            index_q <= '0;
            snap_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            snap_q  <= snap_d;
            valid_q <= (state_d == SEND);
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    assign bus.dump_valid_o = valid_q;
    assign bus.dump_index_o = index_q;
    assign bus.dump_data_o  = snap_q;
    assign bus.dump_busy_o  = busy_q;
    assign bus.dump_done_o  = done_q;

    assign bus.data_0_o  = '0;
    assign bus.data_1_o  = regs[1];   assign bus.data_2_o  = regs[2];   assign bus.data_3_o  = regs[3];
    assign bus.data_4_o  = regs[4];   assign bus.data_5_o  = regs[5];   assign bus.data_6_o  = regs[6];
    assign bus.data_7_o  = regs[7];   assign bus.data_8_o  = regs[8];   assign bus.data_9_o  = regs[9];
    assign bus.data_10_o = regs[10];  assign bus.data_11_o = regs[11];  assign bus.data_12_o = regs[12];
    assign bus.data_13_o = regs[13];  assign bus.data_14_o = regs[14];  assign bus.data_15_o = regs[15];
    assign bus.data_16_o = regs[16];  assign bus.data_17_o = regs[17];  assign bus.data_18_o = regs[18];
    assign bus.data_19_o = regs[19];  assign bus.data_20_o = regs[20];  assign bus.data_21_o = regs[21];
    assign bus.data_22_o = regs[22];  assign bus.data_23_o = regs[23];  assign bus.data_24_o = regs[24];
    assign bus.data_25_o = regs[25];  assign bus.data_26_o = regs[26];  assign bus.data_27_o = regs[27];
    assign bus.data_28_o = regs[28];  assign bus.data_29_o = regs[29];  assign bus.data_30_o = regs[30];
    assign bus.data_31_o = regs[31];
endmodule

// File: tb/tb_register_bank_dump.sv
// Bench for register_bank_dump: directed scenarios plus random traffic against a
// cycle-level reference model of the register file and dump stream.
module tb_register_bank_dump;
    localparam int unsigned N = 32;
    localparam logic [31:0] GP = 32'h1000_8000;
    localparam logic [31:0] SP = 32'h7FFF_EFFC;

    logic        clk = 1'b0;
    logic        reset;
    logic        we, start, ready;
    logic [4:0]  wa;
    logic [31:0] wd;
    int          passed = 0;
    int          total  = 0;

    register_bank_dump_if #(.N(N)) bus ();

    register_bank_dump #(.N(N), .GP_RESET(GP), .SP_RESET(SP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.reg_write_i      = we;
    assign bus.write_register_i = wa;
    assign bus.write_data_i     = wd;
    assign bus.dump_start_i     = start;
    assign bus.dump_ready_i     = ready;

    logic [31:0] obs [32];
    assign obs[0]  = bus.data_0_o;   assign obs[1]  = bus.data_1_o;   assign obs[2]  = bus.data_2_o;
    assign obs[3]  = bus.data_3_o;   assign obs[4]  = bus.data_4_o;   assign obs[5]  = bus.data_5_o;
    assign obs[6]  = bus.data_6_o;   assign obs[7]  = bus.data_7_o;   assign obs[8]  = bus.data_8_o;
    assign obs[9]  = bus.data_9_o;   assign obs[10] = bus.data_10_o;  assign obs[11] = bus.data_11_o;
    assign obs[12] = bus.data_12_o;  assign obs[13] = bus.data_13_o;  assign obs[14] = bus.data_14_o;
    assign obs[15] = bus.data_15_o;  assign obs[16] = bus.data_16_o;  assign obs[17] = bus.data_17_o;
    assign obs[18] = bus.data_18_o;  assign obs[19] = bus.data_19_o;  assign obs[20] = bus.data_20_o;
    assign obs[21] = bus.data_21_o;  assign obs[22] = bus.data_22_o;  assign obs[23] = bus.data_23_o;
    assign obs[24] = bus.data_24_o;  assign obs[25] = bus.data_25_o;  assign obs[26] = bus.data_26_o;
    assign obs[27] = bus.data_27_o;  assign obs[28] = bus.data_28_o;  assign obs[29] = bus.data_29_o;
    assign obs[30] = bus.data_30_o;  assign obs[31] = bus.data_31_o;

    // Reference model: architectural registers, dump phase (0 idle, 1 sending, 2 done),
    // current beat position and the value it carries.
    logic [31:0] m [32];
    int          m_phase, m_idx;
    logic [31:0] m_snap;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m[i] = 32'h0;
        m[28] = GP;
        m[29] = SP;
        m_phase = 0;
        m_idx   = 0;
        m_snap  = 32'h0;
    endtask

    // Write is applied first, so a beat that advances onto a just-written register sees the new value
    task automatic model_edge();
        if (we && wa != 5'd0) m[wa] = wd;
        case (m_phase)
            0: if (start) begin m_phase = 1; m_idx = 0; m_snap = m[0]; end
            1: if (ready) begin
                   if (m_idx == 31) m_phase = 2;
                   else begin m_idx++; m_snap = m[m_idx]; end
               end
            default: m_phase = 0;
        endcase
    endtask

    task automatic compare_dump();
        check("dump_valid", 32'(bus.dump_valid_o), 32'(m_phase == 1));
        check("dump_busy",  32'(bus.dump_busy_o),  32'(m_phase != 0));
        check("dump_done",  32'(bus.dump_done_o),  32'(m_phase == 2));
        check("dump_index", 32'(bus.dump_index_o), 32'(m_idx));
        check("dump_data",  bus.dump_data_o,       m_snap);
    endtask

    task automatic compare_regs();
        for (int i = 0; i < 32; i++) check($sformatf("data_%0d", i), obs[i], m[i]);
    endtask

    task automatic cycle();
        int k;
        @(posedge clk);
        model_edge();
        #1;
        compare_dump();
        k = $urandom_range(0, 31);
        check($sformatf("data_%0d", k), obs[k], m[k]);
        check("data_0", obs[0], 32'h0);
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("rst_valid", 32'(bus.dump_valid_o), 32'h0);
        check("rst_index", 32'(bus.dump_index_o), 32'h0);
        check("rst_data",  bus.dump_data_o,       32'h0);
        check("rst_busy",  32'(bus.dump_busy_o),  32'h0);
        check("rst_done",  32'(bus.dump_done_o),  32'h0);
        compare_regs();
        @(negedge clk) reset = 1'b0;
    endtask

    // mode 0 plain, 1 backpressure at index 7, 2 write-first at index 9, 3 check post-reset values
    task automatic run_dump(input int mode, output int nvalid, output int done_at, output int idx7);
        int stalls = 0;
        nvalid = 0; done_at = 0; idx7 = 0;
        start = 1'b1; ready = 1'b1; we = 1'b0;
        cycle();
        start = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            if (bus.dump_valid_o) nvalid++;
            if (bus.dump_valid_o && bus.dump_index_o == 5'd7) idx7++;
            if (bus.dump_done_o && done_at == 0) done_at = c;
            we = 1'b0; ready = 1'b1;
            if (mode == 1 && m_phase == 1 && m_idx == 7) begin
                check("bp_hold_data", bus.dump_data_o, 32'h77);
                if (stalls < 3) begin ready = 1'b0; we = 1'b1; wa = 5'd7; wd = 32'hAAAA; stalls++; end
            end
            if (mode == 2 && m_phase == 1 && m_idx == 9) begin we = 1'b1; wa = 5'd10; wd = 32'h5555; end
            if (mode == 2 && m_phase == 1 && m_idx == 10) check("wf_beat10", bus.dump_data_o, 32'h5555);
            if (mode == 3 && m_phase == 1 && m_idx == 29) check("beat29_sp", bus.dump_data_o, SP);
            if (mode == 3 && m_phase == 1 && m_idx == 28) check("beat28_gp", bus.dump_data_o, GP);
            cycle();
        end
        we = 1'b0;
    endtask

    initial begin
        int nv, da, i7;
        reset = 1'b1; we = 1'b0; start = 1'b0; ready = 1'b0; wa = 5'd0; wd = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_dump();
        compare_regs();
        @(negedge clk) reset = 1'b0;

        // Write path and $zero
        we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF;
        cycle();
        check("w5_direct", obs[5], 32'hDEAD_BEEF);
        wa = 5'd0; wd = 32'h1234_5678;
        cycle();
        check("w0_direct", obs[0], 32'h0);
        we = 1'b0;

        // Full dump with ready held high
        for (int k = 1; k < 32; k++) begin
            we = 1'b1; wa = 5'(k); wd = 32'(k * 32'h11);
            cycle();
        end
        we = 1'b0;
        compare_regs();
        run_dump(0, nv, da, i7);
        check("full_beats", 32'(nv), 32'd32);
        check("full_done_cycle", 32'(da), 32'd33);

        // Backpressure with a write to the held register
        run_dump(1, nv, da, i7);
        check("bp_idx7_cycles", 32'(i7), 32'd4);
        check("bp_beats", 32'(nv), 32'd35);
        check("bp_done_cycle", 32'(da), 32'd36);
        check("bp_reg7", obs[7], 32'hAAAA);

        // Write-first capture
        run_dump(2, nv, da, i7);
        check("wf_beats", 32'(nv), 32'd32);

        // Reset in the middle of a dump, then a fresh dump of reset values
        start = 1'b1; ready = 1'b1;
        cycle();
        start = 1'b0;
        for (int c = 0; c < 20 && m_idx < 15; c++) cycle();
        check("mid_reached_15", 32'(m_idx), 32'd15);
        async_reset();
        run_dump(3, nv, da, i7);
        check("post_rst_beats", 32'(nv), 32'd32);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            we    = 1'($urandom_range(0, 1));
            wa    = 5'($urandom);
            wd    = $urandom;
            start = ($urandom_range(0, 7) == 0);
            ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        we = 1'b0; start = 1'b0;
        compare_regs();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
